// File: rtl/add_accum.sv
// rtl/add_accum.sv - framed accumulator of (a + b + cin) beats with result handshake
module add_accum #(
    parameter int W  = 8,
    parameter int AW = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_a,
    input  logic [W-1:0]    in_b,
    input  logic            in_cin,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_sum,
    output logic            out_ovf,
    output logic [AW-W-1:0] out_beats
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [AW-W-1:0]  beats_q, beats_d;

    logic [W:0]       beat_val;
    logic [AW:0]      sum_ext;
    logic             accept;

    // Beat value is W+1 bits wide so the a+b+cin carry is never lost.
    assign beat_val = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
    // One extra bit on the running sum exposes the carry out of bit AW-1.
    assign sum_ext  = {1'b0, acc_q} + {{(AW-W){1'b0}}, beat_val};

    // Ready depends only on state, never on in_valid.
    assign in_ready  = (state_q != DONE);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);

    // The result registers double as the accumulator; they freeze in DONE and IDLE.
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign out_beats = beats_q;

    // Next-state and accumulator update logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        beats_d = beats_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = AW'(beat_val);
                    ovf_d   = 1'b0;
                    beats_d = (AW-W)'(1);
                    state_d = in_last ? DONE : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d   = sum_ext[AW-1:0];
                    ovf_d   = ovf_q | sum_ext[AW];
                    beats_d = beats_q + (AW-W)'(1);
                    if (in_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset discards any partial frame or pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            beats_q <= beats_d;
        end
    end

endmodule

// File: tb/tb_add_accum.sv
// tb/tb_add_accum.sv - scoreboard bench for add_accum
module tb_add_accum;

    localparam int W  = 8;
    localparam int AW = 12;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic            in_cin;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [AW-1:0]   out_sum;
    logic            out_ovf;
    logic [AW-W-1:0] out_beats;

    add_accum #(.W(W), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_beats (out_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int ovf;
        int beats;
    } result_t;

    result_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int  m_acc;
    int  m_ovf;
    int  m_beats;
    bit  m_in_frame;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // One clock cycle of input drive; the model follows only if the beat is accepted.
    task automatic drive_cycle(input bit v, input int a, input int b, input bit c, input bit last);
        bit rdy;
        int bv;
        in_valid = v;
        in_a     = W'(a);
        in_b     = W'(b);
        in_cin   = c;
        in_last  = last;
        rdy = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (v && rdy) begin
            bv = (a % 256) + (b % 256) + int'(c);
            if (!m_in_frame) begin
                m_acc   = bv;
                m_beats = 1;
                m_ovf   = 0;
            end else begin
                m_acc   = m_acc + bv;
                if (m_acc >= (1 << AW)) m_ovf = 1;
                m_acc   = m_acc % (1 << AW);
                m_beats = (m_beats + 1) % (1 << (AW-W));
            end
            if (last) begin
                result_t r;
                r.sum = m_acc; r.ovf = m_ovf; r.beats = m_beats;
                exp_q.push_back(r);
                m_in_frame = 0;
            end else begin
                m_in_frame = 1;
            end
        end
    endtask

    // Offer a beat, waiting (bounded) for in_ready first.
    task automatic send_beat(input int a, input int b, input bit c, input bit last);
        int budget = 50;
        while (!in_ready && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) check("in_ready_timeout", 0, 1);
        drive_cycle(1'b1, a, b, c, last);
    endtask

    // Expect a result right after the last beat, hold it for hold_cycles, then accept it.
    task automatic collect(input string tag, input int hold_cycles);
        result_t r;
        check({tag, "_valid_latency"}, int'(out_valid), 1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 0, 1);
            return;
        end
        r = exp_q.pop_front();
        check({tag, "_sum"},   int'(out_sum),   r.sum);
        check({tag, "_ovf"},   int'(out_ovf),   r.ovf);
        check({tag, "_beats"}, int'(out_beats), r.beats);
        check({tag, "_in_ready_low"}, int'(in_ready), 0);
        for (int i = 0; i < hold_cycles; i++) begin
            // offer a beat during backpressure; it must not be taken
            drive_cycle(1'b1, 99, 99, 1'b1, 1'b1);
            check({tag, "_hold_valid"}, int'(out_valid), 1);
            check({tag, "_hold_ready"}, int'(in_ready), 0);
            check({tag, "_hold_sum"},   int'(out_sum), r.sum);
            check({tag, "_hold_beats"}, int'(out_beats), r.beats);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_after_valid"}, int'(out_valid), 0);
        check({tag, "_after_ready"}, int'(in_ready), 1);
        check({tag, "_idle_keep_sum"}, int'(out_sum), r.sum);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        m_acc = 0; m_ovf = 0; m_beats = 0; m_in_frame = 0;

        #2;
        check("rst_in_ready",  int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sum",   int'(out_sum), 0);
        check("rst_out_beats", int'(out_beats), 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // three-beat frame, no backpressure
        send_beat(10, 20, 1'b0, 1'b0);
        send_beat(255, 1, 1'b1, 1'b0);
        send_beat(3, 4, 1'b0, 1'b1);
        check("three_sum_const", int'(out_sum), 294);
        collect("three", 0);

        // single-beat frame
        send_beat(255, 255, 1'b1, 1'b1);
        check("single_sum_const", int'(out_sum), 511);
        collect("single", 0);

        // overflow frame
        for (int i = 0; i < 9; i++) send_beat(255, 255, 1'b1, i == 8);
        check("ovf_sum_const", int'(out_sum), 503);
        check("ovf_flag_const", int'(out_ovf), 1);
        collect("ovf", 0);

        // backpressure
        send_beat(7, 8, 1'b1, 1'b0);
        send_beat(100, 50, 1'b0, 1'b1);
        collect("bp", 5);

        // reset mid-frame
        send_beat(40, 40, 1'b0, 1'b0);
        send_beat(50, 50, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        m_in_frame = 0;
        #1;
        check("midrst_sum",   int'(out_sum), 0);
        check("midrst_beats", int'(out_beats), 0);
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_ready", int'(in_ready), 1);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(1, 1, 1'b0, 1'b1);
        check("postrst_sum_const", int'(out_sum), 2);
        collect("postrst", 0);

        // gaps: junk on idle cycles must be ignored
        drive_cycle(1'b1, 5, 6, 1'b0, 1'b0);
        drive_cycle(1'b0, 200, 200, 1'b1, 1'b1);
        drive_cycle(1'b0, 17, 3, 1'b1, 1'b1);
        drive_cycle(1'b1, 9, 9, 1'b1, 1'b1);
        check("gap_beats_const", int'(out_beats), 2);
        collect("gap", 0);

        // a few random frames with random backpressure
        for (int f = 0; f < 4; f++) begin
            int n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++)
                send_beat($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)), i == n-1);
            collect("rand", $urandom_range(0, 3));
        end

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
